// File: rtl/counter_seq_pkg.sv
// ============================================================================
// Module      : counter_seq_pkg
// Description : Shared types and constants for the counter sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package counter_seq_pkg;

    // Sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    // Width of the optional wrap event counter
    localparam int WRAP_CNT_W = 8;

endpackage

`default_nettype wire

// File: rtl/counter_core.sv
// ============================================================================
// Module      : counter_core
// Description : WIDTH-bit up/down counter register with synchronous load,
//               step enable and a combinational modulo-wrap flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module counter_core #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             enable,
    input  logic             dir,
    output logic [WIDTH-1:0] count,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] MIN_VAL = {WIDTH{1'b0}};

    // A step wraps when counting up from all-ones or down from zero
    assign wrap = enable && !load && (dir ? (count == MAX_VAL) : (count == MIN_VAL));

    // Counter register: load has priority over a step
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= MIN_VAL;
        end else if (load) begin
            count <= load_val;
        end else if (enable) begin
            count <= dir ? (count + 1'b1) : (count - 1'b1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/counter_sequencer.sv
// ============================================================================
// Module      : counter_sequencer
// Description : Three-state (IDLE/RUN/HOLD) run controller around an up/down
//               counter with one-shot or auto-reload terminal handling.
//               Optional feature macro COUNTER_SEQUENCER_WRAP_CNT_EN adds the
//               saturating 8-bit wrap_cnt output.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module counter_sequencer
    import counter_seq_pkg::*;
#(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    input  logic             dir,
    input  logic             auto_reload,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] term_val,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done
`ifdef COUNTER_SEQUENCER_WRAP_CNT_EN
    ,
    output logic [WRAP_CNT_W-1:0] wrap_cnt
`endif
);

    state_t state;
    state_t state_next;
    logic   core_load;
    logic   core_en;
    logic   core_wrap;
    logic   done_next;
    logic   start_edge;

    counter_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk      (clk),
        .reset    (reset),
        .load     (core_load),
        .load_val (load_val),
        .enable   (core_en),
        .dir      (dir),
        .count    (count),
        .wrap     (core_wrap)
    );

    assign start_edge = (state == IDLE) && start;
    assign busy       = (state == RUN) || (state == HOLD);

    // Next-state and counter control; priority in RUN is stop > terminal > pause > step
    always_comb begin
        state_next = state;
        core_load  = 1'b0;
        core_en    = 1'b0;
        done_next  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    core_load  = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (stop) begin
                    state_next = IDLE;
                end else if (count == term_val) begin
                    done_next = 1'b1;
                    if (auto_reload) begin
                        core_load = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end else if (pause) begin
                    state_next = HOLD;
                end else begin
                    core_en = 1'b1;
                end
            end
            HOLD: begin
                if (stop) begin
                    state_next = IDLE;
                end else if (!pause) begin
                    state_next = RUN;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and terminal pulse registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            done  <= done_next;
        end
    end

`ifdef COUNTER_SEQUENCER_WRAP_CNT_EN
    // Saturating count of wrap steps, cleared when a run starts
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wrap_cnt <= '0;
        end else if (start_edge) begin
            wrap_cnt <= '0;
        end else if (core_wrap && (wrap_cnt != {WRAP_CNT_W{1'b1}})) begin
            wrap_cnt <= wrap_cnt + 1'b1;
        end
    end
`else
    // Wrap flag and start decode only feed the optional counter
    logic unused_wrap;
    assign unused_wrap = core_wrap ^ start_edge;
`endif

endmodule

`default_nettype wire

// File: tb/tb_counter_sequencer.sv
// ============================================================================
// Module      : tb_counter_sequencer
// Description : Directed self-checking bench for counter_sequencer (WIDTH=3).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_counter_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       stop;
    logic       pause;
    logic       dir;
    logic       auto_reload;
    logic [2:0] load_val;
    logic [2:0] term_val;
    logic [2:0] count;
    logic       busy;
    logic       done;
`ifdef COUNTER_SEQUENCER_WRAP_CNT_EN
    logic [7:0] wrap_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    counter_sequencer #(
        .WIDTH (3)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .stop        (stop),
        .pause       (pause),
        .dir         (dir),
        .auto_reload (auto_reload),
        .load_val    (load_val),
        .term_val    (term_val),
        .count       (count),
        .busy        (busy),
        .done        (done)
`ifdef COUNTER_SEQUENCER_WRAP_CNT_EN
        ,
        .wrap_cnt    (wrap_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input int c, input int b, input int d);
        chk({tag, ".count"}, 32'(count), 32'(c));
        chk({tag, ".busy"},  32'(busy),  32'(b));
        chk({tag, ".done"},  32'(done),  32'(d));
    endtask

    initial begin
        int exp_cnt [6];
        int exp_done[6];

        reset = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0;
        dir = 1'b1; auto_reload = 1'b0; load_val = 3'd0; term_val = 3'd0;

        // Reset held for three cycles
        repeat (3) tick();
        chk_out("rst", 0, 0, 0);
`ifdef COUNTER_SEQUENCER_WRAP_CNT_EN
        chk("rst.wrap_cnt", 32'(wrap_cnt), 0);
`endif
        reset = 1'b1;
        tick();
        chk_out("idle", 0, 0, 0);

        // One-shot up 2 -> 5, start while running is ignored
        load_val = 3'd2; term_val = 3'd5; dir = 1'b1; auto_reload = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        chk_out("up0", 2, 1, 0);
        tick(); chk_out("up1", 3, 1, 0);
        start = 1'b1; tick(); start = 1'b0;
        chk_out("up2", 4, 1, 0);
        tick(); chk_out("up3", 5, 1, 0);
        tick(); chk_out("up_done", 5, 0, 1);
        tick(); chk_out("up_after", 5, 0, 0);
`ifdef COUNTER_SEQUENCER_WRAP_CNT_EN
        chk("up.wrap_cnt", 32'(wrap_cnt), 0);
`endif

        // Down with wrap 1 -> 0 -> 7 -> 6
        load_val = 3'd1; term_val = 3'd6; dir = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        chk_out("dn0", 1, 1, 0);
        tick(); chk_out("dn1", 0, 1, 0);
        tick(); chk_out("dn2", 7, 1, 0);
        tick(); chk_out("dn3", 6, 1, 0);
        tick(); chk_out("dn_done", 6, 0, 1);
`ifdef COUNTER_SEQUENCER_WRAP_CNT_EN
        chk("dn.wrap_cnt", 32'(wrap_cnt), 1);
`endif

        // Auto-reload 0 -> 2, then stop mid-run
        load_val = 3'd0; term_val = 3'd2; dir = 1'b1; auto_reload = 1'b1;
        exp_cnt  = '{1, 2, 0, 1, 2, 0};
        exp_done = '{0, 0, 1, 0, 0, 1};
        start = 1'b1; tick(); start = 1'b0;
        chk_out("ar0", 0, 1, 0);
`ifdef COUNTER_SEQUENCER_WRAP_CNT_EN
        chk("ar.wrap_clr", 32'(wrap_cnt), 0);
`endif
        for (int i = 0; i < 6; i++) begin
            tick();
            chk_out($sformatf("ar%0d", i + 1), exp_cnt[i], 1, exp_done[i]);
        end
        tick(); chk_out("ar7", 1, 1, 0);
        stop = 1'b1; tick(); stop = 1'b0;
        chk_out("ar_stop", 1, 0, 0);
        auto_reload = 1'b0;

        // Pause for one sampled edge at count 3 costs two cycles
        load_val = 3'd0; term_val = 3'd6; dir = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        chk_out("ps0", 0, 1, 0);
        tick(); chk_out("ps1", 1, 1, 0);
        tick(); chk_out("ps2", 2, 1, 0);
        tick(); chk_out("ps3", 3, 1, 0);
        pause = 1'b1; tick(); pause = 1'b0;
        chk_out("ps_hold", 3, 1, 0);
        tick(); chk_out("ps_resume", 3, 1, 0);
        tick(); chk_out("ps4", 4, 1, 0);
        tick(); chk_out("ps5", 5, 1, 0);
        tick(); chk_out("ps6", 6, 1, 0);
        tick(); chk_out("ps_done", 6, 0, 1);

        // Zero-length run
        load_val = 3'd4; term_val = 3'd4;
        start = 1'b1; tick(); start = 1'b0;
        chk_out("z0", 4, 1, 0);
        tick(); chk_out("z_done", 4, 0, 1);

        // Stop while in HOLD
        load_val = 3'd5; term_val = 3'd2;
        start = 1'b1; tick(); start = 1'b0;
        chk_out("hs0", 5, 1, 0);
        pause = 1'b1; tick();
        chk_out("hs_hold", 5, 1, 0);
        stop = 1'b1; tick(); stop = 1'b0; pause = 1'b0;
        chk_out("hs_stop", 5, 0, 0);
        tick(); chk_out("hs_idle", 5, 0, 0);

        // Asynchronous reset mid-cycle at count 3
        load_val = 3'd0; term_val = 3'd6;
        start = 1'b1; tick(); start = 1'b0;
        tick(); tick(); tick();
        chk_out("ar_pre", 3, 1, 0);
        #2 reset = 1'b0;
        #1 chk_out("arst_now", 0, 0, 0);
        tick();
        reset = 1'b1;
        tick(); chk_out("arst_after", 0, 0, 0);
        load_val = 3'd3;
        start = 1'b1; tick(); start = 1'b0;
        chk_out("arst_restart", 3, 1, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
